axi_wr_rr_arbiter: RTL and testbench
====================================

Name: axi_wr_rr_arbiter

Overview:
- Sequencing write-channel arbiter for the 3-master / 8-slave AXI bus.
- Grants one master, latches its AWADDR and decodes the target slave, then holds that grant through the AW, W and B phases.
- Releases the grant on the B handshake and rotates priority round-robin among M0, M1 and M2.
- Drives the select lines of the AW/W/B muxes in the bus top.

Parameters:
- NUM_M, 3, number of write masters; fixed at 3 in this revision.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- ACLK  in  1  bus clock
- ARESETn  in  1  synchronous active-low reset
- AWVALID_M0/M1/M2  in  1 each  master write-address valid
- AWADDR_M0/M1/M2  in  32 each  master write address
- AWREADY_SEL  in  1  AWREADY of the currently selected slave
- WVALID_SEL, WREADY_SEL, WLAST_SEL  in  1 each  W signals of the granted pair
- BVALID_SEL, BREADY_SEL  in  1 each  B signals of the granted pair
- grant_valid  out  1  a grant is active
- grant_mst  out  2  granted master index, 0..2
- grant_slv  out  4  decoded slave: 0..7 = S0..S7; 8 = default slave (DECERR)
- timeout_err  out  1  one-cycle pulse; only with WR_TIMEOUT_EN, otherwise tied 0

Behaviour:
- Reset values (next ACLK edge with ARESETn=0, including mid-transaction):
  - state = IDLE, grant_valid = 0, grant_mst = 0, grant_slv = 8
  - rr_ptr = 0, timeout_err = 0
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Search the request vector {AWVALID_M2, AWVALID_M1, AWVALID_M0} starting at rr_ptr, wrapping 2 to 0.
  - First requester wins. Register grant_mst, latch its AWADDR, register the decoded grant_slv, go to ADDR.
  - grant_valid = 1 from the next cycle, i.e. 1-cycle grant latency.
  - No requests: stay in IDLE.
- ADDR: wait for AWVALID_Mgrant & AWREADY_SEL.
  - AW handshake alone: go to DATA.
  - AW handshake in the same cycle as WVALID_SEL & WREADY_SEL & WLAST_SEL: go directly to RESP.
- DATA: on WVALID_SEL & WREADY_SEL & WLAST_SEL, go to RESP. Non-last beats keep the state.
- RESP: on BVALID_SEL & BREADY_SEL:
  - go to IDLE, grant_valid = 0
  - rr_ptr = (grant_mst == 2) ? 0 : grant_mst + 1
- A new grant may be issued in the cycle after return to IDLE. There is no back-to-back grant in the same cycle as the B handshake.
- Grant outputs are stable from grant until the B handshake. Requests from other masters are ignored while a grant is active.
- Decode uses the latched address only:
  - [31:16] = 0x0000: S0 ROM
  - [31:16] = 0x0001: S1 IM
  - [31:16] = 0x0002: S2 DM
  - [31:16] = 0x1000: S3 Sctrl
  - [31:16] = 0x1001: S4 WDT
  - [31:24] = 0x20: S5 DRAM
  - [31:16] = 0x0010: S6 EPU
  - [31:16] = 0x0003: S7 DMA
  - anything else: 8 (default slave)
- An unmapped address still runs the full ADDR, DATA, RESP sequence. The default slave responds.

Optional Feature:
- Macro WR_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ADDR and increments each cycle in ADDR, DATA and RESP.
  - When it reaches TIMEOUT_CYC-1 with no exiting handshake: force IDLE, pulse timeout_err for 1 cycle, clear grant_valid, advance rr_ptr as for normal completion.
  - A handshake in the same cycle as the limit takes priority and no error is raised.
- Not defined: no counter is built, timeout_err is constant 0, and the arbiter waits indefinitely.

Decomposition:
- Package axi_wr_arb_pkg holds:
  - state enum
  - slave ID constants S0..S7 and SDEF = 8
  - address-map region constants
- One combinational sub-module, wr_addr_decode: 32-bit address in, 4-bit slave ID out. It is shared later with the read arbiter.

Test Plan:
- Single M1 write to 0x0002_0010, 1 beat, slave ready immediately. Required: grant_mst = 1 and grant_slv = 2 one cycle after AWVALID; state sequence ADDR, DATA, RESP, IDLE; rr_ptr = 2 afterwards.
- All three masters request continuously, each writing 0x2000_0000. Required: grant order M0, M1, M2, M0; every grant_slv = 5.
- M0 write to 0x0010_0004 with AW and WLAST handshaking in the same cycle. Required: ADDR goes directly to RESP; grant_slv = 6.
- M2 write to 0x4000_0000. Required: grant_slv = 8; full sequence completes on the default-slave B response.
- ARESETn = 0 during DATA of an M1 burst. Required: next edge gives grant_valid = 0, grant_slv = 8, rr_ptr = 0; the next request from M0 is granted first.
- With WR_TIMEOUT_EN and TIMEOUT_CYC = 16, hold BVALID_SEL = 0. Required: timeout_err pulses 16 cycles after grant and the state returns to IDLE. Without the macro, grant_valid stays 1.

Source files
------------

// File: rtl/axi_wr_arb_pkg.sv
// Shared types and address map for the AXI write/read arbiters.
package axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } wr_state_e;

    localparam logic [3:0] S0   = 4'd0;
    localparam logic [3:0] S1   = 4'd1;
    localparam logic [3:0] S2   = 4'd2;
    localparam logic [3:0] S3   = 4'd3;
    localparam logic [3:0] S4   = 4'd4;
    localparam logic [3:0] S5   = 4'd5;
    localparam logic [3:0] S6   = 4'd6;
    localparam logic [3:0] S7   = 4'd7;
    localparam logic [3:0] SDEF = 4'd8;

    // Upper address halfword per slave; DRAM matches on the top byte only
    localparam logic [15:0] RGN_ROM   = 16'h0000;
    localparam logic [15:0] RGN_IM    = 16'h0001;
    localparam logic [15:0] RGN_DM    = 16'h0002;
    localparam logic [15:0] RGN_SCTRL = 16'h1000;
    localparam logic [15:0] RGN_WDT   = 16'h1001;
    localparam logic [7:0]  RGN_DRAM  = 8'h20;
    localparam logic [15:0] RGN_EPU   = 16'h0010;
    localparam logic [15:0] RGN_DMA   = 16'h0003;

endpackage

// File: rtl/axi_wr_rr_arbiter_if.sv
// Request/select bundle between the bus top and the write arbiter.
interface axi_wr_rr_arbiter_if;

    logic        AWVALID_M0;
    logic        AWVALID_M1;
    logic        AWVALID_M2;
    logic [31:0] AWADDR_M0;
    logic [31:0] AWADDR_M1;
    logic [31:0] AWADDR_M2;
    logic        AWREADY_SEL;
    logic        WVALID_SEL;
    logic        WREADY_SEL;
    logic        WLAST_SEL;
    logic        BVALID_SEL;
    logic        BREADY_SEL;
    logic        grant_valid;
    logic [1:0]  grant_mst;
    logic [3:0]  grant_slv;
    logic        timeout_err;

    modport master (
        output AWVALID_M0, AWVALID_M1, AWVALID_M2,
        output AWADDR_M0, AWADDR_M1, AWADDR_M2,
        output AWREADY_SEL, WVALID_SEL, WREADY_SEL, WLAST_SEL,
        output BVALID_SEL, BREADY_SEL,
        input  grant_valid, grant_mst, grant_slv, timeout_err
    );

    modport slave (
        input  AWVALID_M0, AWVALID_M1, AWVALID_M2,
        input  AWADDR_M0, AWADDR_M1, AWADDR_M2,
        input  AWREADY_SEL, WVALID_SEL, WREADY_SEL, WLAST_SEL,
        input  BVALID_SEL, BREADY_SEL,
        output grant_valid, grant_mst, grant_slv, timeout_err
    );

endinterface

// File: rtl/wr_addr_decode.sv
// Address to slave-ID decoder, shared by the write and read arbiters.
module wr_addr_decode
    import axi_wr_arb_pkg::*;
(
    input  logic [31:0] addr,
    output logic [3:0]  slv
);

    logic [15:0] unused_lo;
    assign unused_lo = addr[15:0];

    always_comb begin
        slv = SDEF;
        unique case (1'b1)
            (addr[31:16] == RGN_ROM):   slv = S0;
            (addr[31:16] == RGN_IM):    slv = S1;
            (addr[31:16] == RGN_DM):    slv = S2;
            (addr[31:16] == RGN_SCTRL): slv = S3;
            (addr[31:16] == RGN_WDT):   slv = S4;
            (addr[31:24] == RGN_DRAM):  slv = S5;
            (addr[31:16] == RGN_EPU):   slv = S6;
            (addr[31:16] == RGN_DMA):   slv = S7;
            default:                    slv = SDEF;
        endcase
    end

endmodule

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin write arbiter holding one grant across AW, W and B phases.
// Optional watchdog built when WR_TIMEOUT_EN is defined.
module axi_wr_rr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_M       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                ACLK,
    input logic                ARESETn,
    axi_wr_rr_arbiter_if.slave bus
);

    wr_state_e   state_q, state_d;
    logic        grant_valid_q, grant_valid_d;
    logic [1:0]  grant_mst_q, grant_mst_d;
    logic [3:0]  grant_slv_q, grant_slv_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;

    logic [2:0]  req;
    logic        found;
    logic [1:0]  win;
    logic [31:0] win_addr;
    logic [3:0]  win_slv;
    logic        aw_valid_g;
    logic        aw_hs, wl_hs, b_hs;
    logic [1:0]  rr_next;

    assign req   = {bus.AWVALID_M2, bus.AWVALID_M1, bus.AWVALID_M0};
    assign found = |req;

    always_comb begin
        win = 2'd0;
        unique case (rr_ptr_q)
            2'd1:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        win_addr = bus.AWADDR_M0;
        unique case (win)
            2'd1:    win_addr = bus.AWADDR_M1;
            2'd2:    win_addr = bus.AWADDR_M2;
            default: win_addr = bus.AWADDR_M0;
        endcase
    end

    wr_addr_decode u_dec (
        .addr (win_addr),
        .slv  (win_slv)
    );

    always_comb begin
        aw_valid_g = bus.AWVALID_M0;
        unique case (grant_mst_q)
            2'd1:    aw_valid_g = bus.AWVALID_M1;
            2'd2:    aw_valid_g = bus.AWVALID_M2;
            default: aw_valid_g = bus.AWVALID_M0;
        endcase
    end

    assign aw_hs   = aw_valid_g & bus.AWREADY_SEL;
    assign wl_hs   = bus.WVALID_SEL & bus.WREADY_SEL & bus.WLAST_SEL;
    assign b_hs    = bus.BVALID_SEL & bus.BREADY_SEL;
    assign rr_next = (grant_mst_q == 2'(NUM_M - 1)) ? 2'd0
                                                     : grant_mst_q + 2'd1;

`ifdef WR_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        hs_exit;

    assign hs_exit = (state_q == ST_ADDR && aw_hs)
                   | (state_q == ST_DATA && wl_hs)
                   | (state_q == ST_RESP && b_hs);
`else
    localparam int unused_tmo = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_mst_d   = grant_mst_q;
        grant_slv_d   = grant_slv_q;
        rr_ptr_d      = rr_ptr_q;
`ifdef WR_TIMEOUT_EN
        timeout_err_d = 1'b0;
        cnt_d         = (state_q == ST_IDLE) ? 16'd0 : cnt_q + 16'd1;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d       = ST_ADDR;
                    grant_valid_d = 1'b1;
                    grant_mst_d   = win;
                    grant_slv_d   = win_slv;
                end
            end
            ST_ADDR: begin
                if (aw_hs) state_d = wl_hs ? ST_RESP : ST_DATA;
            end
            ST_DATA: begin
                if (wl_hs) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = rr_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef WR_TIMEOUT_EN
        // A handshake landing on the limit cycle wins over the watchdog
        if (state_q != ST_IDLE && !hs_exit && cnt_q >= TMO_LIM) begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
            rr_ptr_d      = rr_next;
            timeout_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_mst_q   <= 2'd0;
            grant_slv_q   <= SDEF;
            rr_ptr_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_mst_q   <= grant_mst_d;
            grant_slv_q   <= grant_slv_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

`ifdef WR_TIMEOUT_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cnt_q         <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_mst   = grant_mst_q;
    assign bus.grant_slv   = grant_slv_q;

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Directed bench for axi_wr_rr_arbiter; timeout scenario follows WR_TIMEOUT_EN.
module tb_axi_wr_rr_arbiter;
    import axi_wr_arb_pkg::*;

    logic ACLK;
    logic ARESETn;
    int   pass_cnt;
    int   total_cnt;

    axi_wr_rr_arbiter_if bus ();

    axi_wr_rr_arbiter #(
        .NUM_M       (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clr_bus();
        bus.AWVALID_M0  = 1'b0;
        bus.AWVALID_M1  = 1'b0;
        bus.AWVALID_M2  = 1'b0;
        bus.AWADDR_M0   = 32'h0;
        bus.AWADDR_M1   = 32'h0;
        bus.AWADDR_M2   = 32'h0;
        bus.AWREADY_SEL = 1'b0;
        bus.WVALID_SEL  = 1'b0;
        bus.WREADY_SEL  = 1'b0;
        bus.WLAST_SEL   = 1'b0;
        bus.BVALID_SEL  = 1'b0;
        bus.BREADY_SEL  = 1'b0;
    endtask

    task automatic set_w(input logic v);
        bus.WVALID_SEL = v;
        bus.WREADY_SEL = v;
        bus.WLAST_SEL  = v;
    endtask

    task automatic set_b(input logic v);
        bus.BVALID_SEL = v;
        bus.BREADY_SEL = v;
    endtask

    task automatic test_reset();
        clr_bus();
        ARESETn = 1'b0;
        step();
        step();
        total_cnt++;
        if (bus.grant_valid !== 1'b0)
            $display("FAIL rst_gv got %0b exp 0", bus.grant_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.grant_mst !== 2'd0)
            $display("FAIL rst_mst got %0d exp 0", bus.grant_mst);
        else pass_cnt++;
        total_cnt++;
        if (bus.grant_slv !== 4'd8)
            $display("FAIL rst_slv got %0d exp 8", bus.grant_slv);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== ST_IDLE || dut.rr_ptr_q !== 2'd0)
            $display("FAIL rst_st got st=%0d rr=%0d exp st=0 rr=0",
                     dut.state_q, dut.rr_ptr_q);
        else pass_cnt++;
        total_cnt++;
        if (bus.timeout_err !== 1'b0)
            $display("FAIL rst_tmo got %0b exp 0", bus.timeout_err);
        else pass_cnt++;
        ARESETn = 1'b1;
    endtask

    task automatic test_single_m1();
        bus.AWVALID_M1 = 1'b1;
        bus.AWADDR_M1  = 32'h0002_0010;
        step();
        total_cnt++;
        if (bus.grant_valid !== 1'b1 || bus.grant_mst !== 2'd1
            || bus.grant_slv !== 4'd2)
            $display("FAIL m1_grant got gv=%0b mst=%0d slv=%0d exp 1/1/2",
                     bus.grant_valid, bus.grant_mst, bus.grant_slv);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== ST_ADDR)
            $display("FAIL m1_addr got st=%0d exp %0d", dut.state_q, ST_ADDR);
        else pass_cnt++;
        bus.AWREADY_SEL = 1'b1;
        step();
        total_cnt++;
        if (dut.state_q !== ST_DATA)
            $display("FAIL m1_data got st=%0d exp %0d", dut.state_q, ST_DATA);
        else pass_cnt++;
        bus.AWVALID_M1  = 1'b0;
        bus.AWREADY_SEL = 1'b0;
        set_w(1'b1);
        step();
        total_cnt++;
        if (dut.state_q !== ST_RESP || bus.grant_valid !== 1'b1)
            $display("FAIL m1_resp got st=%0d gv=%0b exp %0d/1",
                     dut.state_q, bus.grant_valid, ST_RESP);
        else pass_cnt++;
        set_w(1'b0);
        set_b(1'b1);
        step();
        set_b(1'b0);
        total_cnt++;
        if (dut.state_q !== ST_IDLE || bus.grant_valid !== 1'b0)
            $display("FAIL m1_idle got st=%0d gv=%0b exp 0/0",
                     dut.state_q, bus.grant_valid);
        else pass_cnt++;
        total_cnt++;
        if (dut.rr_ptr_q !== 2'd2)
            $display("FAIL m1_rr got %0d exp 2", dut.rr_ptr_q);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_m [4];
        exp_m[0] = 2'd0;
        exp_m[1] = 2'd1;
        exp_m[2] = 2'd2;
        exp_m[3] = 2'd0;
        test_reset();
        bus.AWVALID_M0 = 1'b1;
        bus.AWVALID_M1 = 1'b1;
        bus.AWVALID_M2 = 1'b1;
        bus.AWADDR_M0  = 32'h2000_0000;
        bus.AWADDR_M1  = 32'h2000_0000;
        bus.AWADDR_M2  = 32'h2000_0000;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++;
            if (bus.grant_valid !== 1'b1 || bus.grant_mst !== exp_m[k]
                || bus.grant_slv !== 4'd5)
                $display("FAIL rr_grant%0d got gv=%0b mst=%0d slv=%0d exp 1/%0d/5",
                         k, bus.grant_valid, bus.grant_mst,
                         bus.grant_slv, exp_m[k]);
            else pass_cnt++;
            bus.AWREADY_SEL = 1'b1;
            set_w(1'b1);
            step();
            bus.AWREADY_SEL = 1'b0;
            set_w(1'b0);
            set_b(1'b1);
            step();
            set_b(1'b0);
        end
        clr_bus();
        total_cnt++;
        if (dut.rr_ptr_q !== 2'd1 || bus.grant_valid !== 1'b0)
            $display("FAIL rr_end got rr=%0d gv=%0b exp 1/0",
                     dut.rr_ptr_q, bus.grant_valid);
        else pass_cnt++;
    endtask

    task automatic test_aw_wlast_same_cycle();
        bus.AWVALID_M0 = 1'b1;
        bus.AWADDR_M0  = 32'h0010_0004;
        step();
        total_cnt++;
        if (bus.grant_mst !== 2'd0 || bus.grant_slv !== 4'd6)
            $display("FAIL m0_grant got mst=%0d slv=%0d exp 0/6",
                     bus.grant_mst, bus.grant_slv);
        else pass_cnt++;
        bus.AWREADY_SEL = 1'b1;
        set_w(1'b1);
        step();
        total_cnt++;
        if (dut.state_q !== ST_RESP)
            $display("FAIL m0_direct got st=%0d exp %0d", dut.state_q, ST_RESP);
        else pass_cnt++;
        clr_bus();
        set_b(1'b1);
        step();
        set_b(1'b0);
        total_cnt++;
        if (dut.state_q !== ST_IDLE || dut.rr_ptr_q !== 2'd1)
            $display("FAIL m0_done got st=%0d rr=%0d exp 0/1",
                     dut.state_q, dut.rr_ptr_q);
        else pass_cnt++;
    endtask

    task automatic test_default_slave();
        bus.AWVALID_M2 = 1'b1;
        bus.AWADDR_M2  = 32'h4000_0000;
        step();
        total_cnt++;
        if (bus.grant_mst !== 2'd2 || bus.grant_slv !== 4'd8)
            $display("FAIL m2_grant got mst=%0d slv=%0d exp 2/8",
                     bus.grant_mst, bus.grant_slv);
        else pass_cnt++;
        bus.AWREADY_SEL = 1'b1;
        step();
        bus.AWVALID_M2  = 1'b0;
        bus.AWREADY_SEL = 1'b0;
        bus.WVALID_SEL  = 1'b1;
        bus.WREADY_SEL  = 1'b1;
        step();
        total_cnt++;
        if (dut.state_q !== ST_DATA)
            $display("FAIL m2_beat got st=%0d exp %0d", dut.state_q, ST_DATA);
        else pass_cnt++;
        bus.WLAST_SEL = 1'b1;
        step();
        set_w(1'b0);
        total_cnt++;
        if (dut.state_q !== ST_RESP || bus.grant_slv !== 4'd8)
            $display("FAIL m2_resp got st=%0d slv=%0d exp %0d/8",
                     dut.state_q, bus.grant_slv, ST_RESP);
        else pass_cnt++;
        set_b(1'b1);
        step();
        set_b(1'b0);
        total_cnt++;
        if (bus.grant_valid !== 1'b0 || dut.rr_ptr_q !== 2'd0)
            $display("FAIL m2_done got gv=%0b rr=%0d exp 0/0",
                     bus.grant_valid, dut.rr_ptr_q);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        bus.AWVALID_M0 = 1'b1;
        step();
        bus.AWREADY_SEL = 1'b1;
        set_w(1'b1);
        step();
        clr_bus();
        set_b(1'b1);
        step();
        clr_bus();
        bus.AWVALID_M1 = 1'b1;
        bus.AWADDR_M1  = 32'h0001_0000;
        step();
        bus.AWREADY_SEL = 1'b1;
        step();
        bus.AWVALID_M1  = 1'b0;
        bus.AWREADY_SEL = 1'b0;
        bus.WVALID_SEL  = 1'b1;
        bus.WREADY_SEL  = 1'b1;
        step();
        total_cnt++;
        if (dut.state_q !== ST_DATA || bus.grant_mst !== 2'd1
            || dut.rr_ptr_q !== 2'd1)
            $display("FAIL mid_pre got st=%0d mst=%0d rr=%0d exp %0d/1/1",
                     dut.state_q, bus.grant_mst, dut.rr_ptr_q, ST_DATA);
        else pass_cnt++;
        clr_bus();
        ARESETn = 1'b0;
        step();
        total_cnt++;
        if (bus.grant_valid !== 1'b0 || bus.grant_slv !== 4'd8
            || dut.rr_ptr_q !== 2'd0 || dut.state_q !== ST_IDLE)
            $display("FAIL mid_rst got gv=%0b slv=%0d rr=%0d st=%0d exp 0/8/0/0",
                     bus.grant_valid, bus.grant_slv, dut.rr_ptr_q, dut.state_q);
        else pass_cnt++;
        ARESETn = 1'b1;
        bus.AWVALID_M0 = 1'b1;
        bus.AWVALID_M1 = 1'b1;
        step();
        total_cnt++;
        if (bus.grant_valid !== 1'b1 || bus.grant_mst !== 2'd0)
            $display("FAIL mid_next got gv=%0b mst=%0d exp 1/0",
                     bus.grant_valid, bus.grant_mst);
        else pass_cnt++;
        clr_bus();
    endtask

    task automatic test_timeout();
        logic bad;
        test_reset();
        bus.AWVALID_M1 = 1'b1;
        step();
        bus.AWREADY_SEL = 1'b1;
        set_w(1'b1);
        step();
        clr_bus();
        bad = 1'b0;
`ifdef WR_TIMEOUT_EN
        for (int i = 2; i < 16; i++) begin
            step();
            if (bus.timeout_err !== 1'b0 || bus.grant_valid !== 1'b1) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0)
            $display("FAIL tmo_early got early=%0b exp 0", bad);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.timeout_err !== 1'b1 || dut.state_q !== ST_IDLE
            || bus.grant_valid !== 1'b0)
            $display("FAIL tmo_fire got tmo=%0b st=%0d gv=%0b exp 1/0/0",
                     bus.timeout_err, dut.state_q, bus.grant_valid);
        else pass_cnt++;
        total_cnt++;
        if (dut.rr_ptr_q !== 2'd2)
            $display("FAIL tmo_rr got %0d exp 2", dut.rr_ptr_q);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.timeout_err !== 1'b0)
            $display("FAIL tmo_pulse got %0b exp 0", bus.timeout_err);
        else pass_cnt++;
`else
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.timeout_err !== 1'b0 || bus.grant_valid !== 1'b1) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0 || dut.state_q !== ST_RESP)
            $display("FAIL notmo_hold got bad=%0b st=%0d exp 0/%0d",
                     bad, dut.state_q, ST_RESP);
        else pass_cnt++;
        set_b(1'b1);
        step();
        set_b(1'b0);
        total_cnt++;
        if (dut.state_q !== ST_IDLE || dut.rr_ptr_q !== 2'd2)
            $display("FAIL notmo_done got st=%0d rr=%0d exp 0/2",
                     dut.state_q, dut.rr_ptr_q);
        else pass_cnt++;
`endif
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        ARESETn   = 1'b0;
        clr_bus();
        test_reset();
        test_single_m1();
        test_round_robin();
        test_aw_wlast_same_cycle();
        test_default_slave();
        test_reset_mid_burst();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
